// File: rtl/sram_like_arbiter_pkg.sv
// Shared encodings for the sram-like arbiter: FSM states, owner ids, transfer sizes.
package sram_like_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADDR = 2'd1,
    WAIT = 2'd2
  } state_t;

  typedef enum logic {
    OWN_INST = 1'b0,
    OWN_DATA = 1'b1
  } owner_t;

  localparam logic [1:0] SIZE_BYTE = 2'd0;
  localparam logic [1:0] SIZE_HALF = 2'd1;
  localparam logic [1:0] SIZE_WORD = 2'd2;

  localparam int STARVE_CNT_W = 4;

endpackage

// File: rtl/sram_like_arbiter_if.sv
// One sram-like port: request fields from the master, handshake and read data from the slave.
interface sram_like_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) ();

  logic              req;
  logic              wr;
  logic [1:0]        size;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] wdata;
  logic              addr_ok;
  logic              data_ok;
  logic [DATA_W-1:0] rdata;

  modport master (
    output req, wr, size, addr, wdata,
    input  addr_ok, data_ok, rdata
  );

  modport slave (
    input  req, wr, size, addr, wdata,
    output addr_ok, data_ok, rdata
  );

endinterface

// File: rtl/sram_like_arbiter_grant.sv
// Pure grant decision shared by the IDLE and WAIT transitions.
// ARB_RR_EN selects strict round-robin; otherwise data priority with a starvation guard.
module sram_like_arbiter_grant
  import sram_like_arbiter_pkg::*;
#(
  parameter int STARVE_MAX = 4
) (
  input  logic                    i_inst_req,
  input  logic                    i_data_req,
`ifdef ARB_RR_EN
  input  owner_t                  i_last_grant,
`else
  input  logic [STARVE_CNT_W-1:0] i_starve_cnt,
`endif
  output logic                    o_grant_data
);

`ifdef ARB_RR_EN
  // On a tie the master that did not win last time goes next.
  assign o_grant_data = (i_inst_req && i_data_req) ? (i_last_grant == OWN_INST) : i_data_req;
`else
  localparam logic [STARVE_CNT_W-1:0] MAX_C = STARVE_CNT_W'(STARVE_MAX);

  assign o_grant_data = i_data_req && !(i_inst_req && (i_starve_cnt == MAX_C));
`endif

endmodule

// File: rtl/sram_like_arbiter.sv
// Shares one sram-like port between fetch and load/store masters, one transaction outstanding.
// ARB_RR_EN defined: round-robin grant; undefined: data priority plus fetch starvation guard.
module sram_like_arbiter
  import sram_like_arbiter_pkg::*;
#(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int STARVE_MAX = 4
) (
  input  logic               clk,
  input  logic               rst,
  sram_like_arbiter_if.slave  i_inst_bus,
  sram_like_arbiter_if.slave  i_data_bus,
  sram_like_arbiter_if.master o_mem_bus
);

  state_t            r_state, w_state_nxt;
  owner_t            r_owner, w_owner_nxt;
  logic              w_any_req;
  logic              w_grant_en;
  logic              w_grant_data;
  logic              w_own_data;
  logic              w_addr_hit;
  logic              w_data_hit;
  logic [ADDR_W-1:0] w_mux_addr;
  logic [DATA_W-1:0] w_mux_wdata;

  assign w_any_req = i_inst_bus.req || i_data_bus.req;

`ifdef ARB_RR_EN
  // The owner register doubles as last_grant; both reset to OWN_INST.
  sram_like_arbiter_grant #(.STARVE_MAX(STARVE_MAX)) u_grant (
    .i_inst_req   (i_inst_bus.req),
    .i_data_req   (i_data_bus.req),
    .i_last_grant (r_owner),
    .o_grant_data (w_grant_data)
  );
`else
  localparam logic [STARVE_CNT_W-1:0] MAX_C = STARVE_CNT_W'(STARVE_MAX);

  logic [STARVE_CNT_W-1:0] r_starve_cnt;

  sram_like_arbiter_grant #(.STARVE_MAX(STARVE_MAX)) u_grant (
    .i_inst_req   (i_inst_bus.req),
    .i_data_req   (i_data_bus.req),
    .i_starve_cnt (r_starve_cnt),
    .o_grant_data (w_grant_data)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_starve_cnt <= '0;
    end else if (w_grant_en) begin
      if (!w_grant_data) begin
        r_starve_cnt <= '0;
      end else if (i_inst_bus.req && (r_starve_cnt != MAX_C)) begin
        r_starve_cnt <= r_starve_cnt + 1'b1;
      end
    end
  end
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= IDLE;
      r_owner <= OWN_INST;
    end else begin
      r_state <= w_state_nxt;
      r_owner <= w_owner_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_owner_nxt = r_owner;
    w_grant_en  = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_any_req) begin
          w_grant_en  = 1'b1;
          w_state_nxt = ADDR;
        end
      end
      ADDR: begin
        if (o_mem_bus.addr_ok) w_state_nxt = WAIT;
      end
      WAIT: begin
        // Re-arbitrate straight into ADDR so back-to-back traffic has no idle bubble.
        if (o_mem_bus.data_ok) begin
          if (w_any_req) begin
            w_grant_en  = 1'b1;
            w_state_nxt = ADDR;
          end else begin
            w_state_nxt = IDLE;
          end
        end
      end
      default: w_state_nxt = IDLE;
    endcase
    if (w_grant_en) w_owner_nxt = w_grant_data ? OWN_DATA : OWN_INST;
  end

  assign w_own_data  = (r_owner == OWN_DATA);
  assign w_mux_addr  = w_own_data ? i_data_bus.addr  : i_inst_bus.addr;
  assign w_mux_wdata = w_own_data ? i_data_bus.wdata : i_inst_bus.wdata;

  assign o_mem_bus.req   = (r_state == ADDR);
  assign o_mem_bus.wr    = w_own_data ? i_data_bus.wr   : i_inst_bus.wr;
  assign o_mem_bus.size  = w_own_data ? i_data_bus.size : i_inst_bus.size;
  assign o_mem_bus.addr  = w_mux_addr;
  assign o_mem_bus.wdata = w_mux_wdata;

  // Responses outside their state are ignored so a stray data_ok cannot reach a master.
  assign w_addr_hit = (r_state == ADDR) && o_mem_bus.addr_ok;
  assign w_data_hit = (r_state == WAIT) && o_mem_bus.data_ok;

  assign i_inst_bus.addr_ok = w_addr_hit && !w_own_data;
  assign i_inst_bus.data_ok = w_data_hit && !w_own_data;
  assign i_data_bus.addr_ok = w_addr_hit && w_own_data;
  assign i_data_bus.data_ok = w_data_hit && w_own_data;
  assign i_inst_bus.rdata   = o_mem_bus.rdata;
  assign i_data_bus.rdata   = o_mem_bus.rdata;

`ifndef SYNTHESIS
  a_data_ok_only_in_wait: assert property (
    @(posedge clk) disable iff (!rst) o_mem_bus.data_ok |-> (r_state == WAIT)
  );
`endif

endmodule
